// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   - funct3 encodings for loads/stores (F3_LB..F3_SW)
//   - grant encodings (GNT_NONE / GNT_I / GNT_D)
//   - funct3 bit range inside an instruction word (IR_F3_HI:IR_F3_LO)
package mem_port_arbiter_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int IR_F3_HI = 14;
   localparam int IR_F3_LO = 12;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2
   } grant_t;

   // Loads with a reserved funct3 return zero.
   function automatic logic f3_is_load(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_align_check.sv
// Alignment checker for data accesses (used only when MISALIGN_TRAP_EN is defined).
// Ports:
//   funct3     in  3  access size/sign encoding
//   addr_lsb   in  2  byte address [1:0]
//   misaligned out 1  halfword with addr[0]=1, or word with addr[1:0]!=0
module mem_align_check
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lsb,
   output logic       misaligned
);

   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         F3_LH, F3_LHU: misaligned = addr_lsb[0];
         F3_LW:         misaligned = |addr_lsb;
         default:       misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one
// single-port byte-addressed memory. One access per cycle; the response is
// registered and presented exactly one cycle after the accept.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned data accesses are
// accepted but suppressed at the memory and flagged via d_misalign).
// Ports:
//   clk, rst                         clock, async active-high reset
//   i_req_* / i_rsp_*                fetch request / response
//   d_req_* / d_rsp_* / d_misalign   load/store request / response
//   mem_*                            memory interface (mem_data_out is combinational)
//
// Grant state
//   reg        | value    | meaning
//   last_grant | GNT_NONE | no accept since reset (data wins contention)
//   last_grant | GNT_I    | last accept was fetch (data wins contention)
//   last_grant | GNT_D    | last accept was data (fetch wins contention)
//   rsp_sel    | GNT_NONE | no response this cycle
//   rsp_sel    | GNT_I    | fetch response valid this cycle
//   rsp_sel    | GNT_D    | data response valid this cycle
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_rsp_valid,
   output logic [DATA_W-1:0] i_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [2:0]        d_req_funct3,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
   output logic              d_misalign,
   output logic              mem_MemRead,
   output logic              mem_MemWrite,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   grant_t            last_grant, last_grant_nxt;
   grant_t            rsp_sel, rsp_sel_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] d_rsp_nxt;
   logic              misalign;
   logic              misalign_q;

   // Fetches are always word aligned; the low address bits are ignored.
   logic unused_i_addr_lsb;
   assign unused_i_addr_lsb = ^i_req_addr[1:0];

`ifdef MISALIGN_TRAP_EN
   mem_align_check u_align_check (
      .funct3     (d_req_funct3),
      .addr_lsb   (d_req_addr[1:0]),
      .misaligned (misalign)
   );
`else
   assign misalign = 1'b0;
`endif

   // Data wins contention unless it won last time; fetch wins otherwise.
   always_comb begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      if (!rst) begin
         if (d_req_valid && (!i_req_valid || last_grant != GNT_D))
            d_req_ready = 1'b1;
         else if (i_req_valid)
            i_req_ready = 1'b1;
      end
   end

   // Memory drive and next grant state. Idle cycles replay the held
   // address/funct3/data so the memory inputs stay quiet.
   always_comb begin
      mem_MemRead    = 1'b0;
      mem_MemWrite   = 1'b0;
      mem_addr       = addr_q;
      mem_funct3     = funct3_q;
      mem_data_in    = wdata_q;
      rsp_sel_nxt    = GNT_NONE;
      last_grant_nxt = last_grant;
      if (d_req_ready) begin
         mem_addr       = d_req_addr;
         mem_funct3     = d_req_funct3;
         if (d_req_we)
            mem_data_in = d_req_wdata;
         mem_MemRead    = !d_req_we && !misalign;
         mem_MemWrite   = d_req_we && !misalign;
         rsp_sel_nxt    = GNT_D;
         last_grant_nxt = GNT_D;
      end else if (i_req_ready) begin
         mem_addr       = {i_req_addr[ADDR_W-1:2], 2'b00};
         rsp_sel_nxt    = GNT_I;
         last_grant_nxt = GNT_I;
      end
   end

   always_comb begin
      d_rsp_nxt = '0;
      if (!d_req_we && !misalign && f3_is_load(d_req_funct3))
         d_rsp_nxt = mem_data_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= GNT_NONE;
         rsp_sel    <= GNT_NONE;
         addr_q     <= '0;
         funct3_q   <= '0;
         wdata_q    <= '0;
         i_rsp_data <= '0;
         d_rsp_data <= '0;
         misalign_q <= 1'b0;
      end else begin
         last_grant <= last_grant_nxt;
         rsp_sel    <= rsp_sel_nxt;
         addr_q     <= mem_addr;
         funct3_q   <= mem_funct3;
         wdata_q    <= mem_data_in;
         misalign_q <= d_req_ready && misalign;
         if (i_req_ready)
            i_rsp_data <= mem_data_out;
         if (d_req_ready)
            d_rsp_data <= d_rsp_nxt;
      end
   end

   assign i_rsp_valid = (rsp_sel == GNT_I);
   assign d_rsp_valid = (rsp_sel == GNT_D);
   assign d_misalign  = misalign_q;

endmodule
